// File: rtl/lab3_bit_serializer_pkg.sv
// Shared definitions for the Lab3 bit serializer: FSM state encoding and
// the default idle level of the serial line. The recognizer bench uses the same idle level.
package lab3_bit_serializer_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } serState_t;

  localparam logic DEFAULT_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/lab3_bit_serializer.sv
// Parallel-to-serial front end for the Lab3 sequence recognizer.
// Takes a WIDTH-bit word over a valid/ready handshake and shifts it out one
// bit per clock on x_out. Back-to-back words are supported with no idle bubble.
// All serial outputs are registered. The outputs are computed from the next-state
// values, so each bit appears in the cycle right after its edge.
module lab3_bit_serializer
  import lab3_bit_serializer_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = DEFAULT_IDLE_LEVEL
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             x_out,
  output logic             x_valid,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  serState_t        r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_cnt;
  logic             r_xOut;
  logic             r_xValid;
  logic             r_done;

  serState_t        w_nextState;
  logic [WIDTH-1:0] w_nextSreg;
  logic [CW-1:0]    w_nextCnt;
  logic             w_nextHead;
  logic             w_accept;

  // Ready depends only on registered state. It is high when idle, or while the final bit of the current word is on the line.
  assign load_ready = (r_state == S_IDLE) || ((r_state == S_SHIFT) && (r_cnt == '0));
  assign w_accept   = load_valid && load_ready;

  // Next-state logic: a new word loads on accept; otherwise the word shifts toward the head. The counter stops at zero.
  always_comb begin
    w_nextState = r_state;
    w_nextSreg  = r_sreg;
    w_nextCnt   = r_cnt;
    if (w_accept) begin
      w_nextState = S_SHIFT;
      w_nextSreg  = load_data;
      w_nextCnt   = CNT_LAST;
    end else if (r_state == S_SHIFT) begin
      w_nextSreg = MSB_FIRST ? {r_sreg[WIDTH-2:0], 1'b0} : {1'b0, r_sreg[WIDTH-1:1]};
      if (r_cnt == '0) begin
        w_nextState = S_IDLE;
      end else begin
        w_nextCnt = r_cnt - 1'b1;
      end
    end
    w_nextHead = MSB_FIRST ? w_nextSreg[WIDTH-1] : w_nextSreg[0];
  end

  // FSM, shift register, counter and registered serial outputs. Synchronous reset aborts any word in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_sreg   <= '0;
      r_cnt    <= '0;
      r_xOut   <= IDLE_LEVEL;
      r_xValid <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_sreg   <= w_nextSreg;
      r_cnt    <= w_nextCnt;
      r_xOut   <= (w_nextState == S_SHIFT) ? w_nextHead : IDLE_LEVEL;
      r_xValid <= (w_nextState == S_SHIFT);
      r_done   <= (w_nextState == S_SHIFT) && (w_nextCnt == '0);
    end
  end

  assign x_out   = r_xOut;
  assign x_valid = r_xValid;
  assign done    = r_done;

endmodule
